// File: rtl/display_scanner_pkg.sv
// Shared constants and helpers for the front-panel display selector.
// Imported by the interface, the scan timer and the top level.
package display_pkg;

   localparam logic [1:0] LED_OFF     = 2'b11;
   localparam int         SEG_BLANK   = 0;
   localparam logic       MODE_MANUAL = 1'b0;
   localparam logic       MODE_AUTO   = 1'b1;

   // Status LEDs are active-low; a masked channel shows both off.
   function automatic logic [1:0] led_map(
      input logic [1:0] flag,
      input logic       en
   );
      return en ? ~flag : LED_OFF;
   endfunction

endpackage

// File: rtl/display_scanner_if.sv
// Panel bus: datapath channels and switches in, display pins out.
// master = board/datapath side, slave = display_scanner.
interface display_scanner_if #(
   parameter int NCH = 4,
   parameter int DW  = 8
);
   localparam int IW = $clog2(NCH);

   logic [NCH*DW-1:0] CH_DATA;
   logic [NCH*2-1:0]  CH_FLAG;
   logic [IW-1:0]     SW_SEL;
   logic              MODE;
   logic              FREEZE;
   logic [DW-1:0]     SEG;
   logic [1:0]        LED;
   logic [IW-1:0]     CH_IDX;

   modport master (
      output CH_DATA, CH_FLAG, SW_SEL, MODE, FREEZE,
      input  SEG, LED, CH_IDX
   );

   modport slave (
      input  CH_DATA, CH_FLAG, SW_SEL, MODE, FREEZE,
      output SEG, LED, CH_IDX
   );
endinterface

// File: rtl/display_scanner_timer.sv
// Dwell counter with wrap-around channel index for auto-scan.
// load takes priority over the advance; clear zeroes the dwell count.
module scan_timer
   import display_pkg::*;
#(
   parameter int NCH      = 4,
   parameter int SCAN_DIV = 50_000_000
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   en_i,
   input  logic                   clr_i,
   input  logic                   load_i,
   input  logic [$clog2(NCH)-1:0] load_val_i,
   output logic [$clog2(NCH)-1:0] idx_o,
   output logic [$clog2(NCH)-1:0] idx_nxt_o
);
   localparam int IW = $clog2(NCH);
   localparam int CW = $clog2(SCAN_DIV);
   localparam logic [CW-1:0] TC   = CW'(SCAN_DIV - 1);
   localparam logic [IW-1:0] LAST = IW'(NCH - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic [IW-1:0] idx_q, idx_d;

   always_comb begin
      cnt_d = cnt_q;
      idx_d = idx_q;
      if (clr_i) cnt_d = '0;
      if (load_i) begin
         idx_d = load_val_i;
      end else if (en_i) begin
         if (cnt_q == TC) begin
            cnt_d = '0;
            // >= also folds an out-of-range manual index back to 0
            idx_d = (idx_q >= LAST) ? '0 : idx_q + 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
         idx_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         idx_q <= idx_d;
      end
   end

   assign idx_o     = idx_q;
   assign idx_nxt_o = idx_d;
endmodule

// File: rtl/display_scanner.sv
// Front-panel selector: channel mux, flag masking, blanking and
// the freeze-able output register around the scan timer.
module display_scanner
   import display_pkg::*;
#(
   parameter int NCH      = 4,
   parameter int DW       = 8,
   parameter int SCAN_DIV = 50_000_000,
   parameter logic [NCH-1:0] FLAG_MASK = NCH'(4'b1000)
) (
   input logic CLK,
   input logic RST_N,
   display_scanner_if.slave bus
);
   localparam int IW = $clog2(NCH);

   logic          frz;
   logic          auto_m;
   logic [IW-1:0] idx;
   logic [IW-1:0] idx_nxt;
   logic [DW-1:0] seg_q, seg_d;
   logic [1:0]    led_q, led_d;

   assign frz    = bus.FREEZE;
   assign auto_m = (bus.MODE == MODE_AUTO);

   // Frozen: timer fully idle, so the dwell count and index hold.
   scan_timer #(
      .NCH      (NCH),
      .SCAN_DIV (SCAN_DIV)
   ) u_timer (
      .clk_i      (CLK),
      .rst_ni     (RST_N),
      .en_i       (!frz && auto_m),
      .clr_i      (!frz && !auto_m),
      .load_i     (!frz && !auto_m),
      .load_val_i (bus.SW_SEL),
      .idx_o      (idx),
      .idx_nxt_o  (idx_nxt)
   );

   always_comb begin
      seg_d = seg_q;
      led_d = led_q;
      if (!frz) begin
         if (int'(idx_nxt) < NCH) begin
            seg_d = bus.CH_DATA[int'(idx_nxt)*DW +: DW];
            led_d = led_map(bus.CH_FLAG[int'(idx_nxt)*2 +: 2],
                            FLAG_MASK[idx_nxt]);
         end else begin
            seg_d = DW'(SEG_BLANK);
            led_d = LED_OFF;
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         seg_q <= DW'(SEG_BLANK);
         led_q <= LED_OFF;
      end else begin
         seg_q <= seg_d;
         led_q <= led_d;
      end
   end

   assign bus.SEG    = seg_q;
   assign bus.LED    = led_q;
   assign bus.CH_IDX = idx;
endmodule
